// File: rtl/systolic_feeder_pkg.sv
// rtl/systolic_feeder_pkg.sv - shared configuration and state type for the activation skew feeder
//
// Contents:
//   sys_rows       - number of systolic array rows (one activation element per row)
//   A_BITWIDTH     - activation element width
//   feeder_cnt_w   - default width of the per-tile vector count
//   feeder_state_e - feeder control state (IDLE, STREAM, DRAIN)

package systolic_feeder_pkg;

  localparam int sys_rows     = 4;
  localparam int A_BITWIDTH   = 8;
  localparam int feeder_cnt_w = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_skew_delay.sv
// rtl/systolic_feeder_skew_delay.sv - DEPTH-stage valid/data shift line for one array row
//
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset, clears every stage
//   in_valid  - element valid entering the line
//   in_data   - element entering the line
//   out_valid - element valid leaving the line DEPTH cycles later
//   out_data  - element leaving the line, zero whenever out_valid is low

module skew_delay #(
  parameter int DEPTH = 1,
  parameter int A_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [A_W-1:0] in_data,
  output logic           out_valid,
  output logic [A_W-1:0] out_data
);

  logic [DEPTH-1:0]          valid_sr;
  logic [DEPTH-1:0][A_W-1:0] data_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_sr <= '0;
      data_sr  <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      // Zero the data at the entry stage so bubbles stay zero all the way down the line.
      data_sr[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        data_sr[i]  <= data_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[DEPTH-1];
  assign out_data  = data_sr[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - activation skew feeder driving per-row enables, data and weight switch
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   cmd_valid  - tile command valid
//   cmd_ready  - command accepted (high only in IDLE)
//   cmd_len    - number of vectors in the tile
//   cmd_switch - request a weight-switch pulse with the first vector
//   in_valid   - activation vector valid
//   in_ready   - vector accepted (high only in STREAM)
//   in_data    - activation vector, element r for row r
//   if_en      - per-row element valid to the array, row r skewed by r cycles
//   if_data    - per-row element to the array, zero when if_en is low
//   switch     - weight-switch pulse, aligned with if_en[0] of the first vector
//   busy       - tile in progress (STREAM or DRAIN)
//   done       - one-cycle pulse with the last vector's if_en[ROWS-1]

module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int ROWS  = sys_rows,
  parameter int A_W   = A_BITWIDTH,
  parameter int CNT_W = feeder_cnt_w
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CNT_W-1:0]          cmd_len,
  input  logic                      cmd_switch,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS-1:0][A_W-1:0]  in_data,
  output logic [ROWS-1:0]           if_en,
  output logic [ROWS-1:0][A_W-1:0]  if_data,
  output logic                      switch,
  output logic                      busy,
  output logic                      done
);

  localparam int DC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DC_W-1:0]  DRAIN_TOP = DC_W'(ROWS - 1);
  localparam logic [DC_W-1:0]  DC_ONE    = DC_W'(1);

  feeder_state_e    state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] vec_cnt;
  logic             switch_req;
  logic [DC_W-1:0]  drain_cnt;
  logic             beat;
  logic             last_beat;

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == STREAM);
  assign busy      = (state != IDLE);

  assign beat      = in_valid && in_ready;
  // vec_cnt is always below len_q while streaming, so the increment cannot wrap here.
  assign last_beat = beat && ((vec_cnt + CNT_ONE) == len_q);

  // The last vector leaves row ROWS-1 exactly ROWS cycles after its beat; DRAIN starts one
  // cycle after the beat at ROWS-1 and counts down, so the zero count lands on that cycle.
  // A zero-length tile enters DRAIN with a zero count and pulses done immediately.
  assign done      = (state == DRAIN) && (drain_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      vec_cnt    <= '0;
      switch_req <= 1'b0;
      drain_cnt  <= '0;
      switch     <= 1'b0;
    end else begin
      // Registered alongside row 0's first stage so it lines up with if_en[0].
      switch <= beat && (vec_cnt == '0) && switch_req;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            len_q      <= cmd_len;
            switch_req <= cmd_switch;
            vec_cnt    <= '0;
            drain_cnt  <= '0;
            state      <= (cmd_len == '0) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (beat) begin
            vec_cnt <= vec_cnt + CNT_ONE;
            if (last_beat) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_TOP;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DC_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Row r sees r+1 register stages, producing the diagonal wavefront the array expects.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay #(
      .DEPTH (r + 1),
      .A_W   (A_W)
    ) u_skew (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (beat),
      .in_data   (in_data[r]),
      .out_valid (if_en[r]),
      .out_data  (if_data[r])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed and randomized bench for systolic_feeder

module tb_systolic_feeder;

  localparam int ROWS  = 4;
  localparam int A_W   = 8;
  localparam int CNT_W = 16;
  localparam int MAXC  = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic [CNT_W-1:0]         cmd_len = '0;
  logic                     cmd_switch = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [ROWS-1:0][A_W-1:0] in_data = '0;
  logic [ROWS-1:0]          if_en;
  logic [ROWS-1:0][A_W-1:0] if_data;
  logic                     switch;
  logic                     busy;
  logic                     done;

  systolic_feeder #(.ROWS(ROWS), .A_W(A_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_switch (cmd_switch),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .if_en      (if_en),
    .if_data    (if_data),
    .switch     (switch),
    .busy       (busy),
    .done       (done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_edge = -1;

  // Reference model: a tile is "active" from command acceptance until the cycle after done.
  // Accepted beats are logged by the edge they were taken on; expected row outputs are read
  // back from that log with the row offset applied.
  bit                       m_active = 1'b0;
  int                       m_rem = 0;
  int                       m_done = -1;
  bit                       m_swp = 1'b0;
  bit                       acc_v [MAXC];
  bit                       sw_at [MAXC];
  logic [ROWS-1:0][A_W-1:0] acc_d [MAXC];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic [ROWS-1:0]          e_en;
    logic [ROWS-1:0][A_W-1:0] e_d;
    logic                     e_sw;
    int                       idx;
    e_en = '0;
    e_d  = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = cyc - 1 - r;
      if (idx > rst_edge && idx >= 0 && acc_v[idx]) begin
        e_en[r] = 1'b1;
        e_d[r]  = acc_d[idx][r];
      end
    end
    e_sw = (cyc - 1 > rst_edge) && sw_at[cyc-1];
    chk("if_en",     64'(if_en),     64'(e_en));
    chk("if_data",   64'(if_data),   64'(e_d));
    chk("switch",    64'(switch),    64'(e_sw));
    chk("done",      64'(done),      64'(m_done == cyc));
    chk("busy",      64'(busy),      64'(m_active));
    chk("cmd_ready", 64'(cmd_ready), 64'(!m_active));
    chk("in_ready",  64'(in_ready),  64'(m_active && m_rem > 0));
  endtask

  task automatic step(input logic r, input logic cv, input logic [CNT_W-1:0] len,
                      input logic csw, input logic iv, input logic [ROWS-1:0][A_W-1:0] d);
    bit cacc;
    bit bacc;
    rst        = r;
    cmd_valid  = cv;
    cmd_len    = len;
    cmd_switch = csw;
    in_valid   = iv;
    in_data    = d;
    cacc = cv && !m_active;
    bacc = iv && m_active && (m_rem > 0);
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_rem    = 0;
      m_done   = -1;
      m_swp    = 1'b0;
      rst_edge = cyc;
    end else if (cacc) begin
      m_active = 1'b1;
      m_rem    = int'(len);
      m_swp    = csw;
      m_done   = (len == '0) ? cyc + 1 : -1;
    end else if (bacc) begin
      acc_v[cyc] = 1'b1;
      acc_d[cyc] = d;
      sw_at[cyc] = m_swp;
      m_swp      = 1'b0;
      m_rem--;
      if (m_rem == 0) m_done = cyc + ROWS;
    end
    cyc++;
    if (m_active && m_done >= 0 && cyc > m_done) m_active = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic beat(input logic [ROWS-1:0][A_W-1:0] d);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1, d);
  endtask

  task automatic cmd(input logic [CNT_W-1:0] len, input logic csw);
    step(1'b0, 1'b1, len, csw, 1'b0, '0);
  endtask

  task automatic wait_free(input string tag);
    int n;
    n = 0;
    while (m_active && n < 50) begin
      idle();
      n++;
    end
    checks++;
    assert (!m_active && cmd_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s_timeout cmd_ready=%b exp=1", tag, cmd_ready);
    end
  endtask

  function automatic logic [ROWS-1:0][A_W-1:0] rand_vec();
    logic [ROWS-1:0][A_W-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r] = A_W'($urandom);
    return v;
  endfunction

  initial begin
    logic [ROWS-1:0][A_W-1:0] d;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 16'd3, 1'b1, 1'b1, rand_vec());
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_if_en",     64'(if_en),     64'd0);
    chk("rst_if_data",   64'(if_data),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    idle();

    // Three back-to-back beats with element pattern 0x10*k + r
    cmd(16'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < ROWS; r++) d[r] = A_W'(8'h10 * k + r);
      beat(d);
    end
    wait_free("len3");

    // One-cycle bubble between two beats
    cmd(16'd2, 1'b0);
    beat(rand_vec());
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, rand_vec());
    beat(rand_vec());
    wait_free("bubble");

    // Weight-switch requested, then not requested
    cmd(16'd1, 1'b1);
    beat(rand_vec());
    wait_free("switch_on");
    cmd(16'd1, 1'b0);
    beat(rand_vec());
    wait_free("switch_off");

    // Zero-length tile
    cmd(16'd0, 1'b1);
    wait_free("len0");

    // Reset in the middle of a stream, then a normal tile
    cmd(16'd4, 1'b1);
    beat(rand_vec());
    beat(rand_vec());
    step(1'b1, 1'b0, '0, 1'b0, 1'b1, rand_vec());
    idle();
    cmd(16'd1, 1'b0);
    beat(rand_vec());
    wait_free("after_rst");

    // Randomized traffic with commands, gaps, switch requests and rare resets
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(3) == 0), CNT_W'($urandom_range(6)),
           1'($urandom_range(1)), ($urandom_range(9) < 7), rand_vec());
    end
    wait_free("random_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Activation skew feeder placed directly upstream of the systolic array. It accepts one activation vector per beat (one element per array row) over a valid/ready handshake. Each row is delayed by its row index so that row i reaches the array i cycles after row 0. It drives the array's per-row enables, row data and weight-switch pulse, and reports tile completion.

Parameters:
ROWS, sys_rows (Config), number of array rows / vector elements
A_W, A_BITWIDTH (Config), activation element width
CNT_W, 16, width of the vector-count field

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  tile command valid
cmd_ready  out  1  high only in IDLE
cmd_len  in  CNT_W  number of vectors in tile
cmd_switch  in  1  request weight-switch pulse with first vector
in_valid  in  1  activation vector valid
in_ready  out  1  feeder accepts vector
in_data  in  [ROWS-1:0][A_W-1:0]  activation vector, element r for row r
if_en  out  ROWS  per-row element valid to array
if_data  out  [ROWS-1:0][A_W-1:0]  per-row element to array
switch  out  1  weight-switch pulse to array
busy  out  1  high in STREAM or DRAIN
done  out  1  one-cycle tile-complete pulse

Behaviour:
- Reset values: cmd_ready=1, in_ready=0, if_en=0, if_data=0, switch=0, busy=0, done=0. Reset also clears all skew registers, counters and the state (state=IDLE).
- FSM states: IDLE, STREAM, DRAIN.
- IDLE: on cmd_valid&cmd_ready, latch cmd_len and cmd_switch, and clear vec_cnt.
  - cmd_len!=0 -> STREAM.
  - cmd_len==0 -> DRAIN with zero drain count: done pulses the next cycle, no if_en or switch is emitted, then return to IDLE.
- STREAM: in_ready=1. A beat is accepted on in_valid&in_ready, and vec_cnt increments.
  - On the beat where vec_cnt reaches cmd_len, go to DRAIN with drain_cnt=ROWS-1.
  - in_valid low produces a bubble: all rows carry if_en=0 for that slot, shifted by the row skew.
- DRAIN: in_ready=0. drain_cnt decrements each cycle.
  - done=1 in the cycle the last vector's if_en[ROWS-1] is high.
  - Next state is IDLE. The next command is accepted no earlier than the cycle after done.
- Skew timing: a beat accepted at edge t gives if_en[r]=1 and if_data[r]=in_data[r] during cycle t+1+r. Row r therefore passes through r+1 registers, and all outputs are registered.
- if_data[r] is forced to 0 whenever if_en[r]=0, so bubbles are deterministic.
- switch: if the latched cmd_switch=1, switch=1 for exactly one cycle, coincident with if_en[0] of the tile's first vector. The array propagates switch row by row, so it stays aligned with the skew.
- Back-to-back accepted beats give back-to-back if_en on every row with no gaps.
- cmd_valid outside IDLE is ignored (cmd_ready=0). in_valid outside STREAM is ignored.
- ROWS=1: DRAIN count is 0, and done coincides with if_en[0] of the last vector.
- vec_cnt has CNT_W bits; the maximum tile is 2^CNT_W-1 vectors, with no wrap within a tile.
- Reset asserted mid-STREAM or mid-DRAIN: outputs return to reset values in the next cycle. In-flight skewed data is discarded and no done is issued.

Decomposition:
- Config package gains the typedef feeder_state_e {IDLE, STREAM, DRAIN}.
- ROWS and A_W come from the existing sys_rows and A_BITWIDTH.
- Sub-module skew_delay (params DEPTH, A_W): a DEPTH-stage shift line carrying valid and data, with synchronous reset. It is instantiated per row with DEPTH=r+1.
- FSM, counters and switch/done generation live in systolic_feeder.

Test Plan:
(All scenarios use ROWS=4, A_W=8.)
1. Reset -> cmd_ready=1; if_en=0, if_data=0, switch=0, busy=0, done=0.
2. cmd_len=3, cmd_switch=0; beats at edges t..t+2 with in_data[r]=8'h10*k+r (k=beat index) -> if_en[r] high in cycles t+1+r..t+3+r and if_data[2] for beat 1 =8'h12 at cycle t+4; done in cycle t+6; cmd_ready=1 in cycle t+7.
3. cmd_len=2 with in_valid low for one cycle between beats -> every row shows pattern 1,0,1 shifted by r; if_data=0 in the gap slot.
4. cmd_switch=1, cmd_len=1 -> switch=1 only in the cycle if_en[0]=1. Repeating with cmd_switch=0 -> switch stays 0.
5. cmd_len=0 -> done pulses the cycle after acceptance; if_en stays 0; busy high for one cycle.
6. Reset asserted two cycles into a cmd_len=4 stream -> all outputs 0 and cmd_ready=1 next cycle, no done. A subsequent cmd_len=1 tile then completes normally.
